// File: rtl/d_flip_flop_pkg.sv
// Shared defaults and parameter legality helper for the d_flip_flop register block.
package d_flip_flop_pkg;

  localparam int DFF_DEFAULT_WIDTH  = 1;
  localparam int DFF_DEFAULT_STAGES = 1;

  function automatic bit dff_params_ok(input int width, input int stages);
    return (width >= 1) && (stages >= 1);
  endfunction

endpackage

// File: rtl/d_flip_flop_stage.sv
// One WIDTH-wide register stage with asynchronous active-low reset to RESET_VALUE.
module d_flip_flop_stage #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q <= RESET_VALUE;
    end else begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/d_flip_flop.sv
// Parameterisable D register: STAGES chained WIDTH-wide stages, q is the last stage.
// Doubles as a fixed delay line or synchroniser chain; every stage resets asynchronously.
module d_flip_flop
  import d_flip_flop_pkg::*;
#(
  parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
  parameter int               STAGES      = DFF_DEFAULT_STAGES,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (!dff_params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("d_flip_flop: WIDTH and STAGES must both be at least 1");
  end

  // w_chain[0] is the input; w_chain[k] is the output of stage k-1.
  logic [WIDTH-1:0] w_chain [0:STAGES];

  assign w_chain[0] = d;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    d_flip_flop_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk  (clk),
      .rstn (rstn),
      .d    (w_chain[i]),
      .q    (w_chain[i+1])
    );
  end

  assign q = w_chain[STAGES];

endmodule

// File: tb/tb_d_flip_flop.sv
// Scoreboard bench: a default 1x1 instance and an 8-bit 3-stage instance (reset 8'hA5) share clk/rstn.
module tb_d_flip_flop;

  localparam int         B_STAGES = 3;
  localparam logic [7:0] B_RESET  = 8'hA5;

  logic       clk;
  logic       rstn;
  logic       d_a;
  logic       q_a;
  logic [7:0] d_b;
  logic [7:0] q_b;

  d_flip_flop u_dut_a (
    .clk  (clk),
    .rstn (rstn),
    .d    (d_a),
    .q    (q_a)
  );

  d_flip_flop #(
    .WIDTH       (8),
    .STAGES      (B_STAGES),
    .RESET_VALUE (B_RESET)
  ) u_dut_b (
    .clk  (clk),
    .rstn (rstn),
    .d    (d_b),
    .q    (q_b)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Reference model: history of values captured since the last reset release.
  // q equals the value captured STAGES-1 edges ago once STAGES captures exist, else the reset value.
  logic       hist_a [$];
  logic [7:0] hist_b [$];

  logic       exp_a_q [$];
  logic [7:0] exp_b_q [$];
  string      name_q  [$];
  event       chk_ev;

  int tests = 0;
  int fails = 0;

  function automatic logic model_a();
    return (hist_a.size() >= 1) ? hist_a[hist_a.size()-1] : 1'b0;
  endfunction

  function automatic logic [7:0] model_b();
    return (hist_b.size() >= B_STAGES) ? hist_b[hist_b.size()-B_STAGES] : B_RESET;
  endfunction

  task automatic push_expect(input string nm);
    exp_a_q.push_back(model_a());
    exp_b_q.push_back(model_b());
    name_q.push_back(nm);
  endtask

  task automatic model_clear();
    hist_a.delete();
    hist_b.delete();
  endtask

  // Wait for a rising edge, apply the capture rule, queue the expected post-edge outputs.
  task automatic edge_update(input string nm);
    @(posedge clk);
    if (rstn) begin
      hist_a.push_back(d_a);
      hist_b.push_back(d_b);
      if (hist_a.size() > 8) void'(hist_a.pop_front());
      if (hist_b.size() > 8) void'(hist_b.pop_front());
    end else begin
      model_clear();
    end
    push_expect(nm);
  endtask

  // Off-edge check, used for asynchronous reset effects.
  task automatic async_check(input string nm);
    push_expect(nm);
    -> chk_ev;
  endtask

  task automatic assert_reset_now(input string nm);
    rstn = 1'b0;
    model_clear();
    #1;
    async_check(nm);
  endtask

  // Monitor: compares at every falling edge and on explicit off-edge requests.
  always begin
    @(negedge clk or chk_ev);
    while (name_q.size() > 0) begin
      logic       ea;
      logic [7:0] eb;
      string      nm;
      ea = exp_a_q.pop_front();
      eb = exp_b_q.pop_front();
      nm = name_q.pop_front();
      tests++;
      if (q_a !== ea) begin
        fails++;
        $display("FAIL %s q_a @%0t: got %b expected %b", nm, $time, q_a, ea);
      end
      tests++;
      if (q_b !== eb) begin
        fails++;
        $display("FAIL %s q_b @%0t: got %h expected %h", nm, $time, q_b, eb);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b1;
    d_a  = 1'b0;
    d_b  = 8'h00;
    #1;
    assert_reset_now("startup_reset");          // t=2
    edge_update("reset_edge10_no_capture");     // t=10
    #5;                                         // t=15
    d_a = 1'b1;
    d_b = 8'h01;
    #10;                                        // t=25
    rstn = 1'b1;
    #2;                                         // t=27
    async_check("released_before_edge");
    edge_update("first_capture_edge30");        // t=30: q_a=1
    #17;                                        // t=47
    assert_reset_now("async_reset_midrun");     // t=48
    edge_update("held_in_reset_edge50");        // t=50
    #5;                                         // t=55
    rstn = 1'b1;
    d_a  = 1'b1;
    d_b  = 8'h01;
    edge_update("resume_ms_d01");               // t=70
    #3 d_b = 8'h02;
    d_a = 1'b0;
    edge_update("ms_d02");
    #3 d_b = 8'h03;
    d_a = 1'b1;
    edge_update("ms_d03_q01");
    #3 d_b = 8'h44;
    edge_update("ms_q02");
    edge_update("ms_q03");

    // Randomised data with glitches between edges; only the last value before each edge counts.
    for (int i = 0; i < 200; i++) begin
      for (int g = 0; g < 3; g++) begin
        #($urandom_range(1, 6));
        d_a = 1'($urandom);
        d_b = 8'($urandom);
      end
      edge_update("random_glitch");
    end

    // Fill the 3-stage pipeline with known non-reset data, then reset off-edge.
    #3 d_b = 8'h11; d_a = 1'b1;
    edge_update("fill1");
    #3 d_b = 8'h22;
    edge_update("fill2");
    #3 d_b = 8'h33;
    edge_update("fill3_q11");
    #17;
    assert_reset_now("reset_full_pipeline");
    edge_update("full_pipeline_held");
    #5 d_b = 8'h3C; d_a = 1'b0;
    #3 rstn = 1'b1;
    edge_update("refill1");
    #3 d_b = 8'hC3; d_a = 1'b1;
    edge_update("refill2");
    #3 d_b = 8'h7E;
    edge_update("refill3_q3C");
    edge_update("refill4_qC3");
    edge_update("refill5_q7E");

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
